// File: rtl/key_cmd_gen_if.sv
// rtl/key_cmd_gen_if.sv - key event input and game command output bundle
interface key_cmd_gen_if;
    logic [1:0] key_num;
    logic       key_valid;
    logic       key_pressed;
    logic       start_pulse;
    logic       left_pulse;
    logic       right_pulse;
    logic [2:0] held;
    logic       repeat_on;

    modport master (
        output key_num,
        output key_valid,
        output key_pressed,
        input  start_pulse,
        input  left_pulse,
        input  right_pulse,
        input  held,
        input  repeat_on
    );

    modport slave (
        input  key_num,
        input  key_valid,
        input  key_pressed,
        output start_pulse,
        output left_pulse,
        output right_pulse,
        output held,
        output repeat_on
    );
endinterface

// File: rtl/key_cmd_gen.sv
// rtl/key_cmd_gen.sv - key events to start/left/right pulses with typematic auto-repeat
module key_cmd_gen #(
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic          clk,
    input  logic          rst,
    key_cmd_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Key codes double as bit indices into held: {right, left, start}.
    localparam logic [1:0] KEY_START = 2'b00;
    localparam logic [1:0] KEY_RIGHT = 2'b10;
    localparam logic [1:0] KEY_NONE  = 2'b11;

    localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;           // 0 = left, 1 = right
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       held_q, held_d;
    logic             start_pulse_q, start_pulse_d;
    logic             left_pulse_q, left_pulse_d;
    logic             right_pulse_q, right_pulse_d;
    logic             repeat_on_q, repeat_on_d;

    logic             ev;
    logic             ev_press;
    logic             ev_release;
    logic [2:0]       key_mask;
    logic             key_is_held;
    logic             key_is_move;
    logic             key_dir;
    logic             other_held;
    logic             term_cnt;
    logic             fire;

    // Next-state: repeat timer first, then the key event, which overrides it.
    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        cnt_d         = cnt_q;
        held_d        = held_q;
        start_pulse_d = 1'b0;
        left_pulse_d  = 1'b0;
        right_pulse_d = 1'b0;

        ev          = bus.key_valid && (bus.key_num != KEY_NONE);
        ev_press    = ev && bus.key_pressed;
        ev_release  = ev && !bus.key_pressed;
        key_mask    = ev ? (3'b001 << bus.key_num) : 3'b000;
        key_is_held = |(held_q & key_mask);
        key_is_move = (bus.key_num != KEY_START);
        key_dir     = (bus.key_num == KEY_RIGHT);
        other_held  = dir_q ? held_q[1] : held_q[2];

        term_cnt = ((state_q == ST_DELAY)  && (cnt_q == DELAY_TC)) ||
                   ((state_q == ST_REPEAT) && (cnt_q == PERIOD_TC));
        // A same-cycle event still lets the timer advance but steals its pulse.
        fire = term_cnt && !ev;

        if (state_q != ST_IDLE) begin
            if (term_cnt) begin
                cnt_d   = '0;
                state_d = ST_REPEAT;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        if (fire) begin
            left_pulse_d  = !dir_q;
            right_pulse_d = dir_q;
        end

        // Presses of an already-held key are keyboard resends and change nothing.
        if (ev_press && !key_is_held) begin
            held_d = held_q | key_mask;
            if (!key_is_move) begin
                start_pulse_d = 1'b1;
            end else begin
                left_pulse_d  = !key_dir;
                right_pulse_d = key_dir;
                dir_d         = key_dir;
                cnt_d         = '0;
                state_d       = ST_DELAY;
            end
        end

        if (ev_release && key_is_held) begin
            held_d = held_q & ~key_mask;
            if (key_is_move && (state_q != ST_IDLE) && (key_dir == dir_q)) begin
                cnt_d = '0;
                if (other_held) begin
                    // Fall back to the still-held direction without an immediate pulse.
                    dir_d   = !dir_q;
                    state_d = ST_DELAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end

        repeat_on_d = (state_d == ST_REPEAT);
    end

    // State and registered outputs; reset drops pending pulses and repeat state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dir_q         <= 1'b0;
            cnt_q         <= '0;
            held_q        <= 3'b000;
            start_pulse_q <= 1'b0;
            left_pulse_q  <= 1'b0;
            right_pulse_q <= 1'b0;
            repeat_on_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            cnt_q         <= cnt_d;
            held_q        <= held_d;
            start_pulse_q <= start_pulse_d;
            left_pulse_q  <= left_pulse_d;
            right_pulse_q <= right_pulse_d;
            repeat_on_q   <= repeat_on_d;
        end
    end

    assign bus.start_pulse = start_pulse_q;
    assign bus.left_pulse  = left_pulse_q;
    assign bus.right_pulse = right_pulse_q;
    assign bus.held        = held_q;
    assign bus.repeat_on   = repeat_on_q;

endmodule

// File: tb/tb_key_cmd_gen.sv
// tb/tb_key_cmd_gen.sv - self-checking bench for key_cmd_gen
module tb_key_cmd_gen;

    localparam int DLY = 8;
    localparam int PER = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    key_cmd_gen_if bus ();

    key_cmd_gen #(
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER),
        .CNT_W        (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: held key set, active direction and the absolute edge
    // number at which the next repeat pulse is due.
    int       edge_n   = 0;
    bit [2:0] m_held   = 3'b000;
    int       m_active = -1;       // -1 none, 1 left, 2 right (key code)
    bit       m_rep    = 1'b0;
    int       m_due    = 0;
    bit       e_start, e_left, e_right;

    logic [6:0] dut_vec;
    logic [6:0] exp_vec;
    assign dut_vec = {bus.start_pulse, bus.left_pulse, bus.right_pulse, bus.held, bus.repeat_on};
    assign exp_vec = {e_start, e_left, e_right, m_held, m_rep};

    task automatic model_step(input bit r, input bit v, input int num, input bit p);
        bit ev;
        int other;
        edge_n++;
        e_start = 0; e_left = 0; e_right = 0;
        if (r) begin
            m_held = 3'b000; m_active = -1; m_rep = 0;
            return;
        end
        ev = v && (num != 3);
        if (m_active > 0 && edge_n == m_due) begin
            m_due = edge_n + PER;
            m_rep = 1;
            if (!ev) begin
                e_left  = (m_active == 1);
                e_right = (m_active == 2);
            end
        end
        if (ev) begin
            if (p && !m_held[num]) begin
                m_held[num] = 1'b1;
                if (num == 0) e_start = 1;
                else begin
                    e_left   = (num == 1);
                    e_right  = (num == 2);
                    m_active = num;
                    m_rep    = 0;
                    m_due    = edge_n + DLY;
                end
            end else if (!p && m_held[num]) begin
                m_held[num] = 1'b0;
                if (num != 0 && m_active == num) begin
                    other = 3 - num;
                    m_rep = 0;
                    if (m_held[other]) begin
                        m_active = other;
                        m_due    = edge_n + DLY;
                    end else begin
                        m_active = -1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [1:0] n, input bit p);
        rst             = r;
        bus.key_valid   = v;
        bus.key_num     = n;
        bus.key_pressed = p;
        @(posedge clk);
        model_step(r, v, int'(n), p);
        @(negedge clk);
        rst           = 1'b0;
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 2'b01, 1);
            n_total++;
            if (dut_vec !== 7'b0) $display("FAIL reset_hold cyc%0d got=%b exp=%b", i, dut_vec, 7'b0);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 2'b11, 0);
            n_total++;
            if (dut_vec !== 7'b0) $display("FAIL reset_idle cyc%0d got=%b exp=%b", i, dut_vec, 7'b0);
            else n_pass++;
        end
    endtask

    task automatic test_start;
        int starts = 0;
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 2'b00, (i < 6));
            starts += int'(bus.start_pulse);
            n_total++;
            if (dut_vec !== exp_vec) $display("FAIL start_seq cyc%0d got=%b exp=%b", i, dut_vec, exp_vec);
            else n_pass++;
            if (i == 0) begin
                n_total++;
                if (bus.start_pulse !== 1'b1 || bus.held !== 3'b001)
                    $display("FAIL start_first got=%b/%b exp=1/001", bus.start_pulse, bus.held);
                else n_pass++;
            end
        end
        n_total++;
        if (starts != 1 || bus.held !== 3'b000) $display("FAIL start_count got=%0d held=%b exp=1 held=000", starts, bus.held);
        else n_pass++;
    endtask

    task automatic test_left_repeat;
        int pulses[$];
        int first_rep = -1;
        int want[4] = '{1, 9, 13, 17};
        for (int i = 0; i < 20; i++) begin
            if (i == 0) step(0, 1, 2'b01, 1);
            else        step(0, 0, 2'b11, 0);
            if (bus.left_pulse) pulses.push_back(i + 1);
            if (bus.repeat_on && first_rep < 0) first_rep = i + 1;
            n_total++;
            if (dut_vec !== exp_vec) $display("FAIL left_rep cyc%0d got=%b exp=%b", i, dut_vec, exp_vec);
            else n_pass++;
        end
        n_total++;
        if (pulses.size() != 4) $display("FAIL left_rep_count got=%0d exp=4", pulses.size());
        else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_total++;
                if (pulses[k] != want[k]) $display("FAIL left_rep_time%0d got=%0d exp=%0d", k, pulses[k], want[k]);
                else n_pass++;
            end
        end
        n_total++;
        if (first_rep != 9) $display("FAIL repeat_on_rise got=%0d exp=9", first_rep);
        else n_pass++;
        step(0, 1, 2'b01, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 2'b11, 0);
            n_total++;
            if (dut_vec !== 7'b0) $display("FAIL left_release cyc%0d got=%b exp=%b", i, dut_vec, 7'b0);
            else n_pass++;
        end
    endtask

    task automatic test_override;
        int lefts = 0;
        int rpos  = -1;
        int lpos  = -1;
        step(0, 1, 2'b01, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 2'b11, 0);
        step(0, 1, 2'b10, 1);
        n_total++;
        if (bus.right_pulse !== 1'b1 || bus.left_pulse !== 1'b0 || dut_vec !== exp_vec)
            $display("FAIL override_press got=%b exp=%b", dut_vec, exp_vec);
        else n_pass++;
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 2'b11, 0);
            lefts += int'(bus.left_pulse);
            if (bus.right_pulse && rpos < 0) rpos = i;
            n_total++;
            if (dut_vec !== exp_vec) $display("FAIL override_run cyc%0d got=%b exp=%b", i, dut_vec, exp_vec);
            else n_pass++;
        end
        n_total++;
        if (rpos != 8 || lefts != 0) $display("FAIL override_next got=%0d lefts=%0d exp=8 lefts=0", rpos, lefts);
        else n_pass++;
        step(0, 1, 2'b10, 0);
        n_total++;
        if (bus.left_pulse !== 1'b0 || bus.right_pulse !== 1'b0 || bus.held !== 3'b010)
            $display("FAIL fallback_release got=%b exp=0 0 010", dut_vec);
        else n_pass++;
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 2'b11, 0);
            if (bus.left_pulse && lpos < 0) lpos = i;
            n_total++;
            if (dut_vec !== exp_vec) $display("FAIL fallback_run cyc%0d got=%b exp=%b", i, dut_vec, exp_vec);
            else n_pass++;
        end
        n_total++;
        if (lpos != 8) $display("FAIL fallback_pulse got=%0d exp=8", lpos);
        else n_pass++;
        step(1, 0, 2'b11, 0);
    endtask

    task automatic test_collision;
        step(0, 1, 2'b01, 1);
        step(0, 1, 2'b10, 1);
        for (int i = 0; i < DLY - 1; i++) step(0, 0, 2'b11, 0);
        // Release of the non-active left key lands on the DELAY expiry edge.
        step(0, 1, 2'b01, 0);
        n_total++;
        if (bus.right_pulse !== 1'b0 || bus.left_pulse !== 1'b0 || bus.held !== 3'b100 || dut_vec !== exp_vec)
            $display("FAIL collision got=%b exp=%b", dut_vec, exp_vec);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 2'b11, 1'($urandom_range(0, 1)));
            n_total++;
            if (dut_vec !== exp_vec) $display("FAIL ignore_11 cyc%0d got=%b exp=%b", i, dut_vec, exp_vec);
            else n_pass++;
        end
        step(1, 0, 2'b11, 0);
    endtask

    task automatic test_reset_mid;
        int any = 0;
        step(0, 1, 2'b10, 1);
        for (int i = 0; i < 11; i++) step(0, 0, 2'b11, 0);
        n_total++;
        if (bus.repeat_on !== 1'b1) $display("FAIL mid_in_repeat got=%b exp=1", bus.repeat_on);
        else n_pass++;
        step(1, 0, 2'b11, 0);
        n_total++;
        if (dut_vec !== 7'b0) $display("FAIL mid_reset got=%b exp=%b", dut_vec, 7'b0);
        else n_pass++;
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 2'b11, 0);
            any += int'(bus.left_pulse | bus.right_pulse | bus.start_pulse | bus.repeat_on);
        end
        n_total++;
        if (any != 0) $display("FAIL mid_quiet got=%0d exp=0", any);
        else n_pass++;
    endtask

    task automatic test_random;
        bit v, p, r;
        logic [1:0] n;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 99) < 30);
            n = 2'($urandom_range(0, 3));
            p = ($urandom_range(0, 99) < 55);
            step(r, v, n, p);
            n_total++;
            if (dut_vec !== exp_vec) $display("FAIL random cyc%0d got=%b exp=%b", i, dut_vec, exp_vec);
            else n_pass++;
            n_total++;
            if (bus.left_pulse && bus.right_pulse) $display("FAIL both_dirs cyc%0d got=11 exp=not both", i);
            else n_pass++;
        end
    endtask

    initial begin
        bus.key_valid   = 1'b0;
        bus.key_num     = 2'b11;
        bus.key_pressed = 1'b0;
        @(negedge clk);
        test_reset();
        test_start();
        test_left_repeat();
        test_override();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
